// File: rtl/pwm_multichannel_generator.sv
// Multichannel edge-aligned PWM generator: one shared prescaler and counter,
// per-channel shadow/active duty registers, three debounced push buttons
// (sum / rest / sel) to edit the selected channel's duty.
// Optional build macro PWM_CENTER_ALIGNED_EN switches to an up/down counter.

// One debounced, edge-detected push button (active-low input).
module pwm_btn_debounce #(
  parameter int DEBOUNCE_BITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);
  localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX = '1;

  logic [1:0]               sync_q, sync_d;
  logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
  logic                     armed_q, armed_d;
  logic                     press_q, press_d;
  logic                     low;

  // Sync, saturating low-time counter, single pulse when it saturates.
  // armed_q only sets after a high level is seen, so a press held across
  // reset is discarded until the button is released.
  always_comb begin
    sync_d  = {sync_q[0], btn_n};
    low     = ~sync_q[1];
    cnt_d   = '0;
    press_d = 1'b0;
    armed_d = 1'b1;
    if (low) begin
      cnt_d   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
      press_d = armed_q && (cnt_q == CNT_MAX - 1'b1);
      armed_d = armed_q && !press_d;
    end
  end

  // Button state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;
endmodule

module pwm_multichannel_generator #(
  parameter int CHANNELS        = 4,
  parameter int FRECUENCY_BITS  = 2,
  parameter int RESOLUTION_BITS = 8,
  parameter int STEP            = 1,
  parameter int DEBOUNCE_BITS   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sum,
  input  logic                          rest,
  input  logic                          sel,
  output logic                          ena,
  output logic [RESOLUTION_BITS-1:0]    value,
  output logic [CHANNELS-1:0]           pwm_out,
  output logic [RESOLUTION_BITS-1:0]    referencia,
  output logic [$clog2(CHANNELS)-1:0]   canal,
  output logic                          update
);
  localparam int R  = RESOLUTION_BITS;
  localparam int CW = $clog2(CHANNELS);
  localparam logic [R-1:0] VMAX   = '1;
  localparam logic [R:0]   STEP_W = (R+1)'(STEP);

  logic [FRECUENCY_BITS-1:0]    presc_q, presc_d;
  logic [R-1:0]                 value_q, value_d;
  logic [CHANNELS-1:0][R-1:0]   shadow_q, shadow_d;
  logic [CHANNELS-1:0][R-1:0]   active_q, active_d;
  logic [CHANNELS-1:0]          pwm_q, pwm_d;
  logic [CW-1:0]                canal_q, canal_d;
  logic [2:0]                   press;   // {sel, rest, sum}
  logic [R-1:0]                 cur;
  logic [R:0]                   sum_w;
  logic                         inc_ok, dec_ok;
`ifdef PWM_CENTER_ALIGNED_EN
  logic                         dir_q, dir_d;   // 1 = counting down
`endif

  // Debounced buttons, one instance per button.
  pwm_btn_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_btn [2:0] (
    .clk   (clk),
    .rst   (rst),
    .btn_n ({sel, rest, sum}),
    .press (press)
  );

  assign ena = &presc_q;
`ifdef PWM_CENTER_ALIGNED_EN
  assign update = ena & (value_q == '0) & ~dir_q;
`else
  assign update = ena & (value_q == VMAX);
`endif

  // Prescaler and shared counter.
  always_comb begin
    presc_d = presc_q + 1'b1;
    value_d = value_q;
`ifdef PWM_CENTER_ALIGNED_EN
    dir_d = dir_q;
    if (ena) begin
      if (!dir_q) begin
        if (value_q == VMAX) begin
          value_d = VMAX - 1'b1;
          dir_d   = 1'b1;
        end else begin
          value_d = value_q + 1'b1;
        end
      end else if (value_q == R'(1)) begin
        value_d = '0;
        dir_d   = 1'b0;
      end else begin
        value_d = value_q - 1'b1;
      end
    end
`else
    if (ena) value_d = value_q + 1'b1;
`endif
  end

  // Button actions on the shadow duties and channel select; shadow-to-active
  // copy on the period boundary; registered PWM compare.
  always_comb begin
    shadow_d = shadow_q;
    cur      = shadow_q[canal_q];
    sum_w    = {1'b0, cur} + STEP_W;
    inc_ok   = press[0] & ~press[1];
    dec_ok   = press[1] & ~press[0];
    if (inc_ok) shadow_d[canal_q] = (sum_w > {1'b0, VMAX}) ? VMAX : sum_w[R-1:0];
    if (dec_ok) shadow_d[canal_q] = ({1'b0, cur} >= STEP_W) ? cur - STEP_W[R-1:0] : '0;
    canal_d = canal_q;
    if (press[2]) canal_d = (canal_q == CW'(CHANNELS-1)) ? '0 : canal_q + 1'b1;
    active_d = update ? shadow_q : active_q;
    for (int i = 0; i < CHANNELS; i++) pwm_d[i] = (value_q < active_q[i]);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q  <= '0;
      value_q  <= '0;
      shadow_q <= '0;
      active_q <= '0;
      pwm_q    <= '0;
      canal_q  <= '0;
`ifdef PWM_CENTER_ALIGNED_EN
      dir_q    <= 1'b0;
`endif
    end else begin
      presc_q  <= presc_d;
      value_q  <= value_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
      canal_q  <= canal_d;
`ifdef PWM_CENTER_ALIGNED_EN
      dir_q    <= dir_d;
`endif
    end
  end

  assign value      = value_q;
  assign pwm_out    = pwm_q;
  assign canal      = canal_q;
  assign referencia = shadow_q[canal_q];
endmodule

// File: tb/tb_pwm_multichannel_generator.sv
// Bench for pwm_multichannel_generator: reset checks, directed button
// sequences and random presses scored against a duty/channel model.
module tb_pwm_multichannel_generator;
  localparam int CH = 4, F = 2, R = 8, STEP = 64, D = 4;
  localparam int VMAX = (1 << R) - 1;
  localparam int PER  = (1 << F) * (1 << R);

  logic clk = 1'b0, rst = 1'b0, sum = 1'b1, rest = 1'b1, sel = 1'b1;
  logic ena, update;
  logic [R-1:0] value, referencia;
  logic [CH-1:0] pwm_out;
  logic [1:0] canal;

  pwm_multichannel_generator #(
    .CHANNELS(CH), .FRECUENCY_BITS(F), .RESOLUTION_BITS(R),
    .STEP(STEP), .DEBOUNCE_BITS(D)
  ) dut (
    .clk(clk), .rst(rst), .sum(sum), .rest(rest), .sel(sel),
    .ena(ena), .value(value), .pwm_out(pwm_out), .referencia(referencia),
    .canal(canal), .update(update)
  );

  always #5 clk = ~clk;

  typedef struct { int c; int r; } exp_t;
  exp_t sbq[$];
  int ncmp = 0, nerr = 0;
  int shadow_m[CH];
  int act_m[CH];
  int hi[CH];
  int canal_m = 0, cyc = 0, last_c = 0, last_r = 0;
  bit mon_en = 1'b0, have_prev = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    ncmp++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Start presses only early in a period so each shadow change settles
  // well before the next boundary.
  task automatic wait_safe();
    int n = 0;
    while (!(value >= 4 && value <= 200)) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        ncmp++; nerr++;
        $display("FAIL safe_window_timeout: got value %0d", value);
        return;
      end
    end
  endtask

  // Drive one button combination low for hold clocks; model predicts the
  // resulting {canal, referencia} and pushes it when it should change.
  task automatic press(input bit s, input bit r, input bit l, input int hold, input bit lat);
    int bc, br, nv;
    wait_safe();
    bc = canal_m; br = shadow_m[canal_m];
    if (hold >= 24) begin
      if (s && !r) begin
        nv = shadow_m[canal_m] + STEP;
        shadow_m[canal_m] = (nv > VMAX) ? VMAX : nv;
      end
      if (r && !s) begin
        nv = shadow_m[canal_m] - STEP;
        shadow_m[canal_m] = (nv < 0) ? 0 : nv;
      end
      if (l) canal_m = (canal_m + 1) % CH;
    end
    if (canal_m != bc || shadow_m[canal_m] != br) sbq.push_back('{canal_m, shadow_m[canal_m]});
    sum = ~s; rest = ~r; sel = ~l;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      if (lat && k == 14) chk("latency_early", int'(referencia), br);
      if (lat && k == 22) chk("latency_late", int'(referencia), shadow_m[canal_m]);
    end
    sum = 1'b1; rest = 1'b1; sel = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Scoreboard monitor: every visible change of {canal, referencia}
  // consumes one predicted entry.
  always @(negedge clk) begin
    if (mon_en && (int'(canal) != last_c || int'(referencia) != last_r)) begin
      last_c = int'(canal); last_r = int'(referencia);
      if (sbq.size() == 0) begin
        ncmp++; nerr++;
        $display("FAIL unexpected_change: got canal %0d ref %0d, expected no change", canal, referencia);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("canal", int'(canal), e.c);
        chk("referencia", int'(referencia), e.r);
      end
    end
  end

  // PWM monitor: high time per channel across each full period between
  // update pulses equals 2^F * duty latched at the earlier pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < CH; i++) hi[i] += int'(pwm_out[i]);
      cyc++;
      if (update) begin
        chk("ena_with_update", int'(ena), 1);
        if (have_prev) begin
          chk("period", cyc, PER);
          for (int i = 0; i < CH; i++)
            chk($sformatf("pwm_high_ch%0d", i), hi[i], (1 << F) * act_m[i]);
        end
        for (int i = 0; i < CH; i++) begin act_m[i] = shadow_m[i]; hi[i] = 0; end
        cyc = 0; have_prev = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int first;
    for (int i = 0; i < CH; i++) begin shadow_m[i] = 0; act_m[i] = 0; hi[i] = 0; end
    repeat (3) @(negedge clk);
    chk("rst_value", int'(value), 0);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_ena", int'(ena), 0);
    rst = 1'b1;
    first = 0;
    for (int k = 1; k <= 8 && first == 0; k++) begin
      @(negedge clk);
      if (ena) first = k;
    end
    chk("first_ena_cycle", first, 3);
    @(negedge clk);
    chk("value_after_first_ena", int'(value), 1);

    // Load some state, then reset asynchronously mid-cycle.
    press(0, 0, 1, 30, 0);
    press(1, 0, 0, 30, 0);
    chk("pre_rst_canal", int'(canal), 1);
    chk("pre_rst_ref", int'(referencia), STEP);
    repeat (37) @(negedge clk);
    @(posedge clk); #3 rst = 1'b0; #1;
    chk("async_rst_value", int'(value), 0);
    chk("async_rst_canal", int'(canal), 0);
    chk("async_rst_ref", int'(referencia), 0);
    chk("async_rst_pwm", int'(pwm_out), 0);
    chk("async_rst_update", int'(update), 0);
    @(negedge clk); rst = 1'b1;
    repeat (5) @(negedge clk);

    // Reset in the middle of a press: press must be discarded.
    sum = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_mid_press", int'(referencia), 0);
    sum = 1'b1;
    repeat (8) @(negedge clk);

    sbq.delete();
    for (int i = 0; i < CH; i++) shadow_m[i] = 0;
    canal_m = 0;
    last_c = int'(canal); last_r = int'(referencia);
    mon_en = 1'b1;

    // Directed sequences.
    press(1, 0, 0, 40, 1);                       // 64 with latency check
    repeat (4) press(1, 0, 0, 30, 0);            // 128,192,255,255
    repeat (5) press(0, 1, 0, 30, 0);            // 191,127,63,0,0
    press(1, 0, 0, 10, 0);                       // glitch: no change
    press(1, 0, 0, 30, 0);                       // 64
    press(1, 1, 0, 40, 0);                       // both: no change
    repeat (5) press(0, 0, 1, 30, 0);            // canal 1,2,3,0,1
    press(1, 0, 0, 30, 0);                       // ch1 = 64
    press(1, 0, 1, 30, 0);                       // ch1 = 128, canal 2

    // Random presses.
    for (int n = 0; n < 40; n++) begin
      bit s, r, l;
      int hold;
      s = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 1));
      if (!s && !r && !l) s = 1'b1;
      hold = ($urandom_range(0, 5) == 0) ? int'($urandom_range(3, 10)) : int'($urandom_range(24, 40));
      press(s, r, l, hold, 0);
    end

    repeat (2 * PER + 50) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/pwm_multichannel_generator.md
# pwm_multichannel_generator

Parametrised successor to the single-channel PWM generator. It drives CHANNELS edge-aligned PWM outputs from one shared prescaler and counter, and each channel has its own duty register. Three active-low push buttons select a channel and step its duty up or down. Duty writes go to a shadow register that takes effect at the period boundary, so no output ever sees a glitched period.

## Interface
- CHANNELS, 4: number of PWM outputs (2..16).
- FRECUENCY_BITS, 2: prescaler width; ena every 2^FRECUENCY_BITS clocks.
- RESOLUTION_BITS, 8: counter/duty width.
- STEP, 1: duty increment/decrement per accepted press.
- DEBOUNCE_BITS, 4: button must be stable low 2^DEBOUNCE_BITS clocks.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- sum  in  1  increment button, active-low, asynchronous.
- rest  in  1  decrement button, active-low, asynchronous.
- sel  in  1  channel-select button, active-low, asynchronous.
- ena  out  1  prescaler tick, one clk wide.
- value  out  RESOLUTION_BITS  shared PWM counter.
- pwm_out  out  CHANNELS  PWM outputs, bit i = channel i.
- referencia  out  RESOLUTION_BITS  shadow duty of the selected channel.
- canal  out  $clog2(CHANNELS)  selected channel index.
- update  out  1  period-boundary pulse; shadow→active copy happens here.

## Operation
- Prescaler counts clk. ena=1 when the prescaler is all-ones.
- value increments on ena and wraps from 2^R−1 to 0.
- Boundary: update = ena & (value == 2^R−1).
  - On update, every active duty is loaded from its shadow.
- Registered pwm_out[i] = (value < active_duty[i]).
  - duty 0 → constant low.
  - duty 2^R−1 → low for exactly one count per period.
- Buttons:
  - Each button has a 2-FF synchroniser and its own debounce counter.
  - The counter increments while the synchronised input is low, clears when it is high, and saturates at 2^D−1.
  - Exactly one press pulse is emitted on the cycle the counter reaches 2^D−1.
  - A held button gives no repeat; it must be released before the next press is accepted.
- Press handling, on the cycle after the pulse:
  - sum: shadow[canal] = min(shadow+STEP, 2^R−1), computed at R+1 bits.
  - rest: shadow[canal] = max(shadow−STEP, 0), no wrap.
  - sum and rest pulses in the same cycle: both ignored.
  - sel: canal = (canal+1) wraps at CHANNELS−1 to 0.
    - sel together with sum/rest in the same cycle: the duty is updated on the old canal, then canal advances.
- referencia = shadow[canal], combinational mux of registered state.

## Timing
- Reset (rst low, async) clears everything to 0: prescaler, value, ena, update, pwm_out, all shadow and active duties, canal, referencia, and the synchroniser and debounce state.
- Reset mid-press: the press is discarded, and the button must go high then low again.
- Press latency: referencia changes 2^D+3 clocks after the input falls (±1 clock, input alignment).
- A shadow change is visible on pwm_out only from the first count after the next update pulse. The current period always completes with its old duty.
- update and ena coincide. pwm_out registers the new active duty one clock after update.
- PWM period = 2^F · 2^R clocks (1024 with defaults).

## Configuration
- PWM_CENTER_ALIGNED_EN defined:
  - value counts up 0..2^R−1, then down 2^R−2..1, repeating.
  - Period = 2^F · (2^(R+1)−2) clocks.
  - update = ena & (value == 0) while counting up, including the first count after reset.
  - pwm_out[i] = (value < active_duty[i]), giving a symmetric pulse.
- Not defined: edge-aligned up-counter as described above. No direction register is synthesised.

## Test plan
- Defaults, rst pulsed low mid-run → all outputs 0 immediately (asynchronous); counting resumes 4 clocks after release with first ena.
- sum held low 40 clocks, canal 0 → referencia 0→1 once at ~19 clocks after the falling edge; after the next update, pwm_out[0] high 4 clocks per 1024.
- sum low for only 10 clocks (glitch) → referencia stays 0; sum and rest pressed together → no change.
- STEP=64: four sum presses → referencia 64,128,192,255 (saturate). Then rest ×5 → 191,127,63,0,0.
- sum press accepted mid-period → pwm_out[0] unchanged until the update pulse, then it follows the new duty from value=0.
- sel ×5 → canal 1,2,3,0,1. Set duty 10 on channel 1 → referencia shows 10 only while canal=1; other channels stay 0.
